// File: rtl/pam4_tx_framer.sv
// PAM4 transmit framer: alternating +3/-3 preamble, then a Gray-mapped PRBS15 payload. Optional 1/(1+D) payload precoding (PAM4_TX_PRECODE_EN).
// Latency: the symbol chosen on a step cycle (i_enable & i_valid) is registered and appears on the next cycle.
// Backpressure: there is no ready input. A non-step cycle freezes all state, and o_sample/o_gray_level hold their value.
module pam4_tx_framer #(
    parameter int          NB_OUT    = 8,
    parameter int          NBF_OUT   = 7,
    parameter int          PRE_LEN   = 64,
    parameter int          PAY_LEN   = 1024,
    parameter logic [14:0] PRBS_SEED = 15'h7FFF
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic                     i_valid,
    input  logic                     i_start,
    input  logic                     i_continuous,
    output logic signed [NB_OUT-1:0] o_sample,
    output logic [1:0]               o_gray_level,
    output logic                     o_valid,
    output logic                     o_preamble,
    output logic                     o_frame_start,
    output logic                     o_busy
);

    localparam logic [14:0] SEED    = (PRBS_SEED == 15'd0) ? 15'h0001 : PRBS_SEED;
    localparam int          CNT_MAX = (PRE_LEN > PAY_LEN) ? PRE_LEN : PAY_LEN;
    localparam int          CW      = $clog2(CNT_MAX) + 1;
    localparam logic signed [NB_OUT-1:0] LVL3 = NB_OUT'(3 << (NBF_OUT - 2));
    localparam logic signed [NB_OUT-1:0] LVL1 = NB_OUT'(1 << (NBF_OUT - 2));

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_PAY  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [14:0]               lfsr_q, lfsr_d, lfsr_mid;
    logic                      step;
    logic                      emit_d;
    logic [1:0]                pay_g, gray_d;
    logic                      pre_d, fs_d;
    logic signed [NB_OUT-1:0]  samp_d;

    logic signed [NB_OUT-1:0]  sample_q;
    logic [1:0]                gray_q;
    logic                      valid_q, preamble_q, frame_start_q;

`ifdef PAM4_TX_PRECODE_EN
    logic [1:0]                prec_q, prec_d;
`endif

    function automatic logic [14:0] lfsr_adv(input logic [14:0] s);
        return {s[13:0], s[14] ^ s[13]};
    endfunction

    function automatic logic signed [NB_OUT-1:0] gray2lvl(input logic [1:0] g);
        logic signed [NB_OUT-1:0] v;
        case (g)
            2'b00:   v = -LVL3;
            2'b01:   v = -LVL1;
            2'b11:   v = LVL1;
            default: v = LVL3;
        endcase
        return v;
    endfunction

    assign lfsr_mid = lfsr_adv(lfsr_q);
    assign pay_g    = {lfsr_q[14], lfsr_mid[14]};

    always_comb begin
        step    = i_enable & i_valid;
        state_d = state_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        emit_d  = 1'b0;
        gray_d  = gray_q;
        pre_d   = 1'b0;
        fs_d    = 1'b0;
`ifdef PAM4_TX_PRECODE_EN
        prec_d  = prec_q;
`endif
        if (step) begin
            case (state_q)
                // IDLE keeps cnt_q at 0, so a start emits preamble symbol 0 on the same step
                ST_IDLE, ST_PRE: begin
                    if (state_q == ST_PRE || i_start) begin
                        emit_d = 1'b1;
                        gray_d = cnt_q[0] ? 2'b00 : 2'b10;
                        pre_d  = 1'b1;
                        fs_d   = (cnt_q == '0);
                        if (cnt_q == CW'(PRE_LEN - 1)) begin
                            state_d = ST_PAY;
                            cnt_d   = '0;
`ifdef PAM4_TX_PRECODE_EN
                            prec_d  = 2'b00;
`endif
                        end else begin
                            state_d = ST_PRE;
                            cnt_d   = cnt_q + CW'(1);
                        end
                    end
                end
                ST_PAY: begin
                    emit_d = 1'b1;
                    lfsr_d = lfsr_adv(lfsr_mid);
`ifdef PAM4_TX_PRECODE_EN
                    prec_d = pay_g - prec_q;
                    gray_d = pay_g - prec_q;
`else
                    gray_d = pay_g;
`endif
                    if (cnt_q == CW'(PAY_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = i_continuous ? ST_PRE : ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        samp_d = gray2lvl(gray_d);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            lfsr_q        <= SEED;
            sample_q      <= '0;
            gray_q        <= 2'b00;
            valid_q       <= 1'b0;
            preamble_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lfsr_q        <= lfsr_d;
            valid_q       <= emit_d;
            frame_start_q <= fs_d;
            if (emit_d) begin
                sample_q   <= samp_d;
                gray_q     <= gray_d;
                preamble_q <= pre_d;
            end
        end
    end

`ifdef PAM4_TX_PRECODE_EN
    always_ff @(posedge i_clock) begin
        if (i_reset) prec_q <= 2'b00;
        else         prec_q <= prec_d;
    end
`endif

    assign o_sample      = sample_q;
    assign o_gray_level  = gray_q;
    assign o_valid       = valid_q;
    assign o_preamble    = preamble_q;
    assign o_frame_start = frame_start_q;
    assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pam4_tx_framer.sv
// Bench for pam4_tx_framer: a reset/preamble vector table, then scoreboarded frames (continuous, stalled, and reset mid-payload).
module tb_pam4_tx_framer;

    localparam int          NB_OUT  = 8;
    localparam int          NBF_OUT = 7;
    localparam int          PRE_LEN = 4;
    localparam int          PAY_LEN = 8;
    localparam logic [14:0] SEED    = 15'h7FFF;

    logic                     clk = 1'b0;
    logic                     i_reset, i_enable, i_valid, i_start, i_continuous;
    logic signed [NB_OUT-1:0] o_sample;
    logic [1:0]               o_gray_level;
    logic                     o_valid, o_preamble, o_frame_start, o_busy;

    always #5 clk = ~clk;

    pam4_tx_framer #(
        .NB_OUT(NB_OUT), .NBF_OUT(NBF_OUT), .PRE_LEN(PRE_LEN),
        .PAY_LEN(PAY_LEN), .PRBS_SEED(SEED)
    ) dut (
        .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
        .i_start(i_start), .i_continuous(i_continuous),
        .o_sample(o_sample), .o_gray_level(o_gray_level), .o_valid(o_valid),
        .o_preamble(o_preamble), .o_frame_start(o_frame_start), .o_busy(o_busy)
    );

    typedef struct {
        logic [1:0] g;
        logic       pre;
        logic       fs;
    } sym_t;

    typedef struct {
        logic rst, en, vld, st, cn;
        logic ev, eb, efs;
        int   es;
    } vec_t;

    sym_t        exp_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [14:0] m_lfsr = SEED;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int lvl(input logic [1:0] g);
        int unit;
        unit = 1 << (NBF_OUT - 2);
        case (g)
            2'b00:   return -3 * unit;
            2'b01:   return -1 * unit;
            2'b11:   return unit;
            default: return 3 * unit;
        endcase
    endfunction

    task automatic next_bit(output logic b);
        b      = m_lfsr[14];
        m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
    endtask

    task automatic push_frames(input int nf);
        logic       b0, b1;
        logic [1:0] g, p;
        for (int f = 0; f < nf; f++) begin
            for (int i = 0; i < PRE_LEN; i++)
                exp_q.push_back('{g: ((i % 2) == 0) ? 2'b10 : 2'b00, pre: 1'b1, fs: (i == 0)});
            p = 2'b00;
            for (int j = 0; j < PAY_LEN; j++) begin
                next_bit(b0);
                next_bit(b1);
                g = {b0, b1};
`ifdef PAM4_TX_PRECODE_EN
                p = g - p;
                g = p;
`endif
                exp_q.push_back('{g: g, pre: 1'b0, fs: 1'b0});
            end
        end
    endtask

    task automatic drive(input logic rst, en, vld, st, cn);
        i_reset      = rst;
        i_enable     = en;
        i_valid      = vld;
        i_start      = st;
        i_continuous = cn;
        @(posedge clk);
        #1;
    endtask

    // Runs nf frames (or only abort_after steps), popping one expectation per step.
    task automatic run(input int nf, input logic cont_last, input bit stall, input int abort_after);
        int   need, done, cyc, nvalid;
        logic en, vld;
        sym_t e;
        logic signed [NB_OUT-1:0] last;
        push_frames(nf);
        need   = (abort_after > 0) ? abort_after : nf * (PRE_LEN + PAY_LEN);
        done   = 0;
        cyc    = 0;
        nvalid = 0;
        last   = o_sample;
        while (done < need && cyc < need * 10 + 50) begin
            en  = 1'b1;
            vld = 1'b1;
            if (stall) begin
                vld = ($urandom_range(0, 1) == 1);
                en  = ($urandom_range(0, 3) != 0);
            end
            drive(1'b0, en, vld, (done == 0), (done == need - 1) ? cont_last : 1'b1);
            cyc++;
            if (o_valid) nvalid++;
            if (en && vld) begin
                done++;
                e = exp_q.pop_front();
                chk("step_valid", int'(o_valid), 1);
                chk("gray", int'(o_gray_level), int'(e.g));
                chk("sample", int'($signed(o_sample)), lvl(e.g));
                chk("preamble", int'(o_preamble), int'(e.pre));
                chk("frame_start", int'(o_frame_start), int'(e.fs));
                last = o_sample;
            end else begin
                chk("stall_valid", int'(o_valid), 0);
                chk("stall_hold", int'($signed(o_sample)), int'(last));
            end
        end
        if (done < need) begin
            n_chk++;
            n_fail++;
            $display("FAIL run_timeout: got %0d steps, expected %0d", done, need);
        end
        if (stall) chk("valid_count", nvalid, done);
        if (abort_after == 0) chk("busy_end", int'(o_busy), int'(cont_last));
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[13];
        //          rst   en    vld   st    cn    ev    eb    efs   es
        vt[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vt[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vt[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vt[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 96};
        vt[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -96};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -96};
        vt[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -96};
        vt[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 96};
        vt[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -96};
        vt[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};

        for (int k = 0; k < 13; k++) begin
            drive(vt[k].rst, vt[k].en, vt[k].vld, vt[k].st, vt[k].cn);
            chk($sformatf("vec%0d_valid", k), int'(o_valid), int'(vt[k].ev));
            chk($sformatf("vec%0d_busy", k), int'(o_busy), int'(vt[k].eb));
            chk($sformatf("vec%0d_fs", k), int'(o_frame_start), int'(vt[k].efs));
            chk($sformatf("vec%0d_sample", k), int'($signed(o_sample)), vt[k].es);
            if (vt[k].ev) chk($sformatf("vec%0d_pre", k), int'(o_preamble), 1);
        end
        chk("reset_gray", int'(o_gray_level), 0);
        chk("reset_pre", int'(o_preamble), 0);
        m_lfsr = SEED;

        // Single frame to IDLE; an idle step afterwards emits nothing.
        run(1, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("idle_step_valid", int'(o_valid), 0);
        chk("idle_step_busy", int'(o_busy), 0);

        // Looping frames without reseeding, then a stalled run that continues the PRBS.
        run(2, 1'b1, 1'b0, 0);
        run(3, 1'b0, 1'b1, 0);

        // Reset mid-payload discards the frame and reseeds the LFSR.
        run(1, 1'b0, 1'b0, PRE_LEN + 3);
        chk("mid_busy", int'(o_busy), 1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_sample", int'($signed(o_sample)), 0);
        chk("rst_gray", int'(o_gray_level), 0);
        chk("rst_pre", int'(o_preamble), 0);
        chk("rst_fs", int'(o_frame_start), 0);
        m_lfsr = SEED;
        run(1, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
